// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: FIFO-buffered 64-bit packets shifted LSB-first with a gated forwarded clock
// and a fixed idle gap between packets. Optional macro SB_TX_PARITY_EN replaces the top bit with even parity.
module sb_tx_serializer #(
  parameter int PKT_W      = 64,
  parameter int GAP_UI     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk_800MHz,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             msg_valid_i,
  input  logic [PKT_W-1:0] msg_data_i,
  output logic             msg_ready_o,
  output logic             SB_clkPin_TX_o,
  output logic             SB_dataPin_TX_o,
  output logic             busy_o,
  output logic [7:0]       tx_pkt_cnt_o
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int TMR_MAX = (PKT_W > 2 * GAP_UI) ? PKT_W : 2 * GAP_UI;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] BIT_LAST = TMR_W'(PKT_W - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(2 * GAP_UI - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state, stateNxt;
  logic [TMR_W-1:0] tmr, tmrNxt;
  logic             ph, phNxt;
  logic             clkNxt, dataNxt;
  logic [PKT_W-1:0] shiftReg, shiftNxt;
  logic             pop, push, pktDone, startOk;

  logic [PKT_W-1:0] fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] fifoCount;
  logic [PKT_W-1:0] headWord, txWord;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign msg_ready_o = (fifoCount < CNT_W'(FIFO_DEPTH));
  assign push        = msg_valid_i && msg_ready_o;
  assign startOk     = (fifoCount != '0) && enable_i;
  assign headWord    = fifoMem[rdPtr];

  always_comb begin
    txWord = headWord;
`ifdef SB_TX_PARITY_EN
    txWord[PKT_W-1] = ^headWord[PKT_W-2:0];
`endif
  end

  always_ff @(posedge clk_800MHz) begin
    if (push) fifoMem[wrPtr] <= msg_data_i;
  end

  always_ff @(posedge clk_800MHz or posedge reset) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push) wrPtr <= nextPtr(wrPtr);
      if (pop)  rdPtr <= nextPtr(rdPtr);
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + CNT_W'(1);
        2'b01:   fifoCount <= fifoCount - CNT_W'(1);
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  always_comb begin
    stateNxt = state;
    tmrNxt   = tmr;
    phNxt    = ph;
    clkNxt   = SB_clkPin_TX_o;
    dataNxt  = SB_dataPin_TX_o;
    shiftNxt = shiftReg;
    pop      = 1'b0;
    pktDone  = 1'b0;
    case (state)
      IDLE: begin
        phNxt = 1'b0;
        if (startOk) pop = 1'b1;
      end
      SHIFT: begin
        phNxt = ~ph;
        if (!ph) begin
          clkNxt = 1'b1;
        end else begin
          clkNxt = 1'b0;
          if (tmr == '0) begin
            stateNxt = GAP;
            tmrNxt   = GAP_LAST;
            dataNxt  = 1'b0;
            pktDone  = 1'b1;
          end else begin
            tmrNxt   = tmr - TMR_W'(1);
            shiftNxt = shiftReg >> 1;
            dataNxt  = shiftReg[1];
          end
        end
      end
      GAP: begin
        phNxt = ~ph;
        if (tmr == '0) begin
          if (startOk) pop = 1'b1;
          else         stateNxt = IDLE;
        end else begin
          tmrNxt = tmr - TMR_W'(1);
        end
      end
      default: stateNxt = IDLE;
    endcase
    // A pop (from IDLE or at gap end) always launches a fresh packet with bit 0 on the pin.
    if (pop) begin
      stateNxt = SHIFT;
      tmrNxt   = BIT_LAST;
      phNxt    = 1'b0;
      clkNxt   = 1'b0;
      shiftNxt = txWord;
      dataNxt  = txWord[0];
    end
  end

  always_ff @(posedge clk_800MHz or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      tmr             <= '0;
      ph              <= 1'b0;
      SB_clkPin_TX_o  <= 1'b0;
      SB_dataPin_TX_o <= 1'b0;
      shiftReg        <= '0;
      busy_o          <= 1'b0;
      tx_pkt_cnt_o    <= 8'd0;
    end else begin
      state           <= stateNxt;
      tmr             <= tmrNxt;
      ph              <= phNxt;
      SB_clkPin_TX_o  <= clkNxt;
      SB_dataPin_TX_o <= dataNxt;
      shiftReg        <= shiftNxt;
      busy_o          <= (stateNxt != IDLE);
      if (pktDone) tx_pkt_cnt_o <= tx_pkt_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Bench for sb_tx_serializer: a pin-level receiver rebuilds packets on SB clock rising edges and
// compares them against a queue of accepted packets; directed timing checks cover pop latency and gaps.
`timescale 1ns/100ps
module tb_sb_tx_serializer;
  localparam int PKT_W = 64;
`ifdef SB_TX_PARITY_EN
  localparam logic PAR7 = 1'b1;
`else
  localparam logic PAR7 = 1'b0;
`endif

  logic             clk_800MHz = 1'b0;
  logic             reset = 1'b1;
  logic             enable_i = 1'b1;
  logic             msg_valid_i = 1'b0;
  logic [PKT_W-1:0] msg_data_i = '0;
  logic             msg_ready_o, SB_clkPin_TX_o, SB_dataPin_TX_o, busy_o;
  logic [7:0]       tx_pkt_cnt_o;

  always #1 clk_800MHz = ~clk_800MHz;

  sb_tx_serializer dut (
    .clk_800MHz      (clk_800MHz),
    .reset           (reset),
    .enable_i        (enable_i),
    .msg_valid_i     (msg_valid_i),
    .msg_data_i      (msg_data_i),
    .msg_ready_o     (msg_ready_o),
    .SB_clkPin_TX_o  (SB_clkPin_TX_o),
    .SB_dataPin_TX_o (SB_dataPin_TX_o),
    .busy_o          (busy_o),
    .tx_pkt_cnt_o    (tx_pkt_cnt_o)
  );

  int               checks = 0;
  int               errors = 0;
  logic [PKT_W-1:0] expQ[$];
  int               rxPkts = 0, rxRises = 0, rxBit = 0, modelCnt = 0;
  logic [PKT_W-1:0] rxWord = '0, rxLast = '0;
  longint           tLastRise = -1, firstGap = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PKT_W-1:0] onWire(input logic [PKT_W-1:0] p);
    logic [PKT_W-1:0] w;
    w = p;
`ifdef SB_TX_PARITY_EN
    w[PKT_W-1] = ^p[PKT_W-2:0];
`endif
    return w;
  endfunction

  // Remote receiver: samples data on each forwarded-clock rising edge.
  always @(posedge SB_clkPin_TX_o or posedge reset) begin
    if (reset) begin
      rxBit     = 0;
      tLastRise = -1;
    end else begin
      rxRises++;
      if (rxBit == 0 && tLastRise >= 0) firstGap = longint'($time) - tLastRise;
      tLastRise = longint'($time);
      rxWord[rxBit] = SB_dataPin_TX_o;
      rxBit++;
      if (rxBit == PKT_W) begin
        rxBit    = 0;
        rxPkts++;
        modelCnt = (modelCnt + 1) % 256;
        rxLast   = rxWord;
        if (expQ.size() == 0) check("rx_extra_pkt", 64'(expQ.size()), 64'd1);
        else                  check("rx_data", rxWord, expQ.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_800MHz);
  endtask

  task automatic push(input logic [PKT_W-1:0] d, input bit hold);
    int guard = 0;
    msg_valid_i = 1'b1;
    msg_data_i  = d;
    while (msg_ready_o !== 1'b1 && guard < 2000) begin
      @(negedge clk_800MHz);
      guard++;
    end
    if (guard >= 2000) check("push_timeout", 64'(guard), 64'd0);
    else               expQ.push_back(onWire(d));
    @(negedge clk_800MHz);
    if (!hold) msg_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((expQ.size() != 0 || busy_o !== 1'b0) && guard < 3000) begin
      @(negedge clk_800MHz);
      guard++;
    end
    check({tag, "_drained"}, 64'(expQ.size()), 64'd0);
    check({tag, "_busy_low"}, 64'(busy_o), 64'd0);
    check({tag, "_pkt_cnt"}, 64'(tx_pkt_cnt_o), 64'(modelCnt));
  endtask

  initial begin
    int firstFull, rx0, guard;
    logic [PKT_W-1:0] r;

    cyc(3);
    reset = 1'b0;
    cyc(2);
    check("rst_ready", 64'(msg_ready_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_clk", 64'(SB_clkPin_TX_o), 64'd0);
    check("rst_data", 64'(SB_dataPin_TX_o), 64'd0);
    check("rst_cnt", 64'(tx_pkt_cnt_o), 64'd0);

    // Single packet: pop one edge after push, then 64 UI and a 64-cycle gap.
    push(64'h1, 1'b0);
    check("t1_no_pop_yet", 64'(busy_o), 64'd0);
    cyc(1);
    check("t1_pop_busy", 64'(busy_o), 64'd1);
    check("t1_bit0_data", 64'(SB_dataPin_TX_o), 64'd1);
    check("t1_bit0_clk", 64'(SB_clkPin_TX_o), 64'd0);
    cyc(1);
    check("t1_bit0_clk_hi", 64'(SB_clkPin_TX_o), 64'd1);
    check("t1_bit0_held", 64'(SB_dataPin_TX_o), 64'd1);
    cyc(126);
    check("t1_bit63_clk_hi", 64'(SB_clkPin_TX_o), 64'd1);
    check("t1_bit63_data", 64'(SB_dataPin_TX_o), 64'd0);
    cyc(1);
    check("t1_gap_busy", 64'(busy_o), 64'd1);
    check("t1_gap_clk", 64'(SB_clkPin_TX_o), 64'd0);
    check("t1_gap_cnt", 64'(tx_pkt_cnt_o), 64'd1);
    cyc(63);
    check("t1_gap_end_busy", 64'(busy_o), 64'd1);
    check("t1_gap_end_pins", 64'({SB_clkPin_TX_o, SB_dataPin_TX_o}), 64'd0);
    cyc(1);
    check("t1_idle_busy", 64'(busy_o), 64'd0);
    check("t1_rises", 64'(rxRises), 64'd64);
    check("t1_rx_pkts", 64'(rxPkts), 64'd1);

    // Back-to-back: next bit0 clock rise 66 cycles (132 ns) after the last rise.
    firstGap = -1;
    push(64'hA5A5_0F0F_DEAD_BEEF, 1'b0);
    push(64'h1234_5678_9ABC_DEF0, 1'b0);
    drain("t2");
    check("t2_gap_ns", 64'(firstGap), 64'd132);
    check("t2_cnt", 64'(tx_pkt_cnt_o), 64'd3);

    // Valid held high across four random packets.
    firstFull = 0;
    for (int i = 0; i < 4; i++) begin
      r = {$urandom, $urandom};
      push(r, 1'b1);
      if (firstFull == 0 && msg_ready_o === 1'b0) firstFull = i + 1;
    end
    msg_valid_i = 1'b0;
    check("t3_accepts_before_full", 64'(firstFull), 64'd3);
    drain("t3");

    // Reset at UI 20 with another packet queued; neither may appear afterwards.
    push({$urandom, $urandom}, 1'b0);
    push({$urandom, $urandom}, 1'b0);
    guard = 0;
    while (rxBit != 20 && guard < 1000) begin
      @(negedge clk_800MHz);
      guard++;
    end
    check("t4_reached_ui20", 64'(rxBit), 64'd20);
    reset = 1'b1;
    expQ.delete();
    modelCnt = 0;
    #0.2;
    check("t4_async_clk", 64'(SB_clkPin_TX_o), 64'd0);
    check("t4_async_data", 64'(SB_dataPin_TX_o), 64'd0);
    check("t4_busy", 64'(busy_o), 64'd0);
    check("t4_ready", 64'(msg_ready_o), 64'd1);
    check("t4_cnt", 64'(tx_pkt_cnt_o), 64'd0);
    cyc(2);
    reset = 1'b0;
    cyc(1);
    push({$urandom, $urandom}, 1'b0);
    drain("t4");

    // enable_i low blocks starts but never an in-flight packet.
    enable_i = 1'b0;
    rx0 = rxPkts;
    push({$urandom, $urandom}, 1'b0);
    push({$urandom, $urandom}, 1'b0);
    cyc(300);
    check("t5_blocked_busy", 64'(busy_o), 64'd0);
    check("t5_blocked_ready", 64'(msg_ready_o), 64'd0);
    check("t5_blocked_rx", 64'(rxPkts), 64'(rx0));
    enable_i = 1'b1;
    guard = 0;
    while (busy_o !== 1'b1 && guard < 20) begin
      @(negedge clk_800MHz);
      guard++;
    end
    enable_i = 1'b0;
    cyc(400);
    check("t5_one_sent_rx", 64'(rxPkts), 64'(rx0 + 1));
    check("t5_one_sent_busy", 64'(busy_o), 64'd0);
    check("t5_one_sent_cnt", 64'(tx_pkt_cnt_o), 64'(modelCnt));
    enable_i = 1'b1;
    drain("t5");

    // Top bit: parity when the macro is defined, data as supplied otherwise.
    push(64'h7, 1'b0);
    drain("t6a");
    check("t6_bit63_of_7", 64'(rxLast[63]), 64'(PAR7));
    push(64'h3, 1'b0);
    drain("t6b");
    check("t6_bit63_of_3", 64'(rxLast[63]), 64'd0);

    // Random traffic with random spacing and enable toggling.
    for (int i = 0; i < 8; i++) begin
      cyc($urandom_range(0, 150));
      enable_i = ($urandom_range(0, 3) != 0);
      push({$urandom, $urandom}, 1'b0);
    end
    enable_i = 1'b1;
    drain("t7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
